// File: rtl/pwm_cap_pkg.sv
// Shared types and defaults for the PWM capture block: FSM encoding,
// default widths, and the result record held in the output slot.
package pwm_cap_pkg;

  localparam int DEF_CNT_W   = 32;
  localparam int DEF_TIMEOUT = 65535;
  localparam int RES_W       = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } cap_state_t;

  // Fields are sized for the widest legal CNT_W; narrower builds zero-extend.
  typedef struct packed {
    logic [RES_W-1:0] period;
    logic [RES_W-1:0] high;
    logic             sat;
    logic             stuck;
    logic             level;
  } cap_result_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronizer chain plus delay flop; provides the synced level and a
// one-cycle rising-edge strobe.
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      dly  <= 1'b0;
    end else begin
      sync[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      dly <= sync[SYNC_STAGES-1];
    end
  end

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~dly;

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM period and high time between rising edges and publishes each
// result, or a stuck-line record on timeout, through a one-deep valid/ready slot.
//
// state | meaning
// IDLE  | waiting for the first rising edge
// MEAS  | counting period/high time since the last rising edge
module pwm_capture
  import pwm_cap_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             m_ready,
  input  logic             ovr_clr,
  output logic             m_valid,
  output logic [CNT_W-1:0] m_period,
  output logic [CNT_W-1:0] m_high,
  output logic             m_sat,
  output logic             m_stuck,
  output logic             m_level,
  output logic             ovr
);

  localparam int TO_W = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s;
  logic             rise;
  cap_state_t       state;
  logic [CNT_W-1:0] per_ctr;
  logic [CNT_W-1:0] high_ctr;
  logic             sat;
  logic [TO_W-1:0]  idle_ctr;
  cap_result_t      slot;
  logic             valid_r;
  logic             ovr_r;

  logic        timeout;
  logic        pub;
  logic        take;
  cap_result_t res;

  pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (pwm_in),
    .s    (s),
    .rise (rise)
  );

  // A rise always beats a coincident timeout.
  always_comb begin
    timeout = (idle_ctr == TO_LAST);
    pub     = 1'b0;
    res     = '0;
    take    = ~valid_r | m_ready;
    if (rise) begin
      if (state == ST_MEAS) begin
        pub        = 1'b1;
        res.period = RES_W'(per_ctr);
        res.high   = RES_W'(high_ctr);
        res.sat    = sat;
      end
    end else if (timeout) begin
      pub       = 1'b1;
      res.stuck = 1'b1;
      res.level = s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      per_ctr  <= '0;
      high_ctr <= '0;
      sat      <= 1'b0;
      idle_ctr <= '0;
      slot     <= '0;
      valid_r  <= 1'b0;
      ovr_r    <= 1'b0;
    end else begin
      if (rise || timeout) idle_ctr <= '0;
      else                 idle_ctr <= idle_ctr + 1'b1;

      if (rise) begin
        state    <= ST_MEAS;
        per_ctr  <= CNT_W'(1);
        high_ctr <= CNT_W'(1);
        sat      <= 1'b0;
      end else if (timeout) begin
        state    <= ST_IDLE;
        per_ctr  <= '0;
        high_ctr <= '0;
        sat      <= 1'b0;
      end else if (state == ST_MEAS) begin
        if (per_ctr == CNT_MAX) sat <= 1'b1;
        else                    per_ctr <= per_ctr + 1'b1;
        if (s) begin
          if (high_ctr == CNT_MAX) sat <= 1'b1;
          else                     high_ctr <= high_ctr + 1'b1;
        end
      end

      if (pub && take) begin
        slot    <= res;
        valid_r <= 1'b1;
      end else if (valid_r && m_ready) begin
        valid_r <= 1'b0;
      end

      // A drop in the same cycle as a clear leaves the flag set.
      ovr_r <= (ovr_r & ~ovr_clr) | (pub & ~take);
    end
  end

  assign m_valid  = valid_r;
  assign m_period = slot.period[CNT_W-1:0];
  assign m_high   = slot.high[CNT_W-1:0];
  assign m_sat    = slot.sat;
  assign m_stuck  = slot.stuck;
  assign m_level  = slot.level;
  assign ovr      = ovr_r;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: three instances (main, short timeout,
// 4-bit counters) share stimulus; accepted results are logged per instance.
module tb_pwm_capture;

  logic clk = 1'b0;
  logic rst, pwm_in, m_ready, ovr_clr;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_valid, a_sat, a_stuck, a_level, a_ovr;
  logic [31:0] a_period, a_high;
  logic        t_valid, t_sat, t_stuck, t_level, t_ovr;
  logic [31:0] t_period, t_high;
  logic        n_valid, n_sat, n_stuck, n_level, n_ovr;
  logic [3:0]  n_period, n_high;

  pwm_capture #(.CNT_W(32), .SYNC_STAGES(2), .TIMEOUT(1000)) u_main (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .m_ready(m_ready), .ovr_clr(ovr_clr),
    .m_valid(a_valid), .m_period(a_period), .m_high(a_high), .m_sat(a_sat),
    .m_stuck(a_stuck), .m_level(a_level), .ovr(a_ovr));

  pwm_capture #(.CNT_W(32), .SYNC_STAGES(2), .TIMEOUT(20)) u_to (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .m_ready(m_ready), .ovr_clr(ovr_clr),
    .m_valid(t_valid), .m_period(t_period), .m_high(t_high), .m_sat(t_sat),
    .m_stuck(t_stuck), .m_level(t_level), .ovr(t_ovr));

  pwm_capture #(.CNT_W(4), .SYNC_STAGES(2), .TIMEOUT(1000)) u_sat (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .m_ready(m_ready), .ovr_clr(ovr_clr),
    .m_valid(n_valid), .m_period(n_period), .m_high(n_high), .m_sat(n_sat),
    .m_stuck(n_stuck), .m_level(n_level), .ovr(n_ovr));

  typedef struct {
    int unsigned per;
    int unsigned hi;
    bit          sat;
    bit          stuck;
    bit          lvl;
    int          cyc;
  } rec_t;

  rec_t q_main[$];
  rec_t q_to[$];
  rec_t q_sat[$];

  always @(negedge clk) begin
    if (!rst && m_ready) begin
      if (a_valid) q_main.push_back('{a_period, a_high, a_sat, a_stuck, a_level, cyc});
      if (t_valid) q_to.push_back('{t_period, t_high, t_sat, t_stuck, t_level, cyc});
      if (n_valid) q_sat.push_back('{32'(n_period), 32'(n_high), n_sat, n_stuck, n_level, cyc});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    pwm_in  = 1'b0;
    m_ready = 1'b0;
    ovr_clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    q_main.delete();
    q_to.delete();
    q_sat.delete();
  endtask

  task automatic pwm_period(input int hi, input int per);
    for (int i = 0; i < per; i++) begin
      pwm_in = (i < hi);
      tick();
    end
  endtask

  task automatic hold_level(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; pwm_in = 1'b0; m_ready = 1'b0; ovr_clr = 1'b0;
    do_reset();
    chk("rst_valid", a_valid, 0);
    chk("rst_period", a_period, 0);
    chk("rst_high", a_high, 0);
    chk("rst_ovr", a_ovr, 0);
    chk("rst_stuck", a_stuck, 0);

    // 3 high / 5 low: back-to-back results of 8/3
    m_ready = 1'b1;
    repeat (6) pwm_period(3, 8);
    hold_level(1'b0, 10);
    chk("p8_count", q_main.size(), 5);
    for (int i = 0; i < q_main.size(); i++) begin
      chk("p8_period", q_main[i].per, 8);
      chk("p8_high", q_main[i].hi, 3);
      chk("p8_sat", q_main[i].sat, 0);
      if (i > 0) chk("p8_gap", q_main[i].cyc - q_main[i-1].cyc, 8);
    end

    // duty steps 30, 13, 5 of period 100
    do_reset();
    m_ready = 1'b1;
    pwm_period(30, 100);
    pwm_period(13, 100);
    pwm_period(5, 100);
    pwm_period(5, 15);
    chk("duty_count", q_main.size(), 3);
    if (q_main.size() == 3) begin
      chk("duty0_high", q_main[0].hi, 30);
      chk("duty1_high", q_main[1].hi, 13);
      chk("duty2_high", q_main[2].hi, 5);
      chk("duty0_period", q_main[0].per, 100);
      chk("duty1_period", q_main[1].per, 100);
      chk("duty2_period", q_main[2].per, 100);
    end

    // backpressure: first result held, later ones dropped
    do_reset();
    pwm_period(2, 10);
    pwm_period(4, 10);
    pwm_period(6, 10);
    pwm_period(1, 6);
    chk("bp_valid", a_valid, 1);
    chk("bp_period", a_period, 10);
    chk("bp_high", a_high, 2);
    chk("bp_ovr", a_ovr, 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("bp_ovr_clr", a_ovr, 0);
    chk("bp_still_valid", a_valid, 1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("bp_drain_valid", a_valid, 0);
    chk("bp_accept_count", q_main.size(), 1);
    if (q_main.size() == 1) chk("bp_accept_high", q_main[0].hi, 2);

    // stuck high / stuck low with TIMEOUT = 20
    do_reset();
    m_ready = 1'b1;
    hold_level(1'b1, 70);
    chk("stk1_count_ge2", q_to.size() >= 2, 1);
    if (q_to.size() >= 2) begin
      chk("stk1_stuck", q_to[0].stuck, 1);
      chk("stk1_level", q_to[0].lvl, 1);
      chk("stk1_period", q_to[0].per, 0);
      chk("stk1_high", q_to[0].hi, 0);
      chk("stk1_repeat", q_to[1].cyc - q_to[0].cyc, 20);
    end
    hold_level(1'b0, 30);
    q_to.delete();
    hold_level(1'b0, 45);
    chk("stk0_count_ge2", q_to.size() >= 2, 1);
    if (q_to.size() >= 2) begin
      chk("stk0_stuck", q_to[0].stuck, 1);
      chk("stk0_level", q_to[0].lvl, 0);
      chk("stk0_period", q_to[0].per, 0);
      chk("stk0_repeat", q_to[1].cyc - q_to[0].cyc, 20);
    end

    // 4-bit counters saturate on a 20-cycle period
    do_reset();
    m_ready = 1'b1;
    pwm_period(5, 20);
    pwm_period(5, 20);
    pwm_period(1, 6);
    chk("sat_count", q_sat.size(), 2);
    if (q_sat.size() >= 1) begin
      chk("sat_period", q_sat[0].per, 15);
      chk("sat_high", q_sat[0].hi, 5);
      chk("sat_flag", q_sat[0].sat, 1);
    end

    // reset mid-measurement with a result held
    do_reset();
    pwm_period(6, 10);
    pwm_period(6, 10);
    hold_level(1'b1, 3);
    chk("mid_held_before_rst", a_valid, 1);
    do_reset();
    chk("mid_valid_after_rst", a_valid, 0);
    chk("mid_period_after_rst", a_period, 0);
    m_ready = 1'b1;
    pwm_period(6, 10);
    chk("mid_no_stale", q_main.size(), 0);
    pwm_period(6, 10);
    pwm_period(1, 6);
    chk("mid_count", q_main.size(), 2);
    if (q_main.size() >= 1) begin
      chk("mid_period", q_main[0].per, 10);
      chk("mid_high", q_main[0].hi, 6);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures the PWM waveform produced by the PWM generator stage. It counts period length and high time in `clk` cycles between consecutive rising edges of `pwm_in`. Each completed measurement is published on a valid/ready result port for a monitor, register bank or self-check logic. It sits directly downstream of the generator's `o_pwm` output and closes the loop on the programmed duty value.

## Interface
- `CNT_W`, 32: width of period/high counters and result fields.
- `SYNC_STAGES`, 2: synchronizer flops on `pwm_in` (legal 1..3).
- `TIMEOUT`, 65535: cycles without a rising edge before a stuck-level result is emitted (legal range ≥ 2).
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pwm_in`  in  1  PWM waveform under measurement.
- `m_ready`  in  1  consumer accepts the result this cycle.
- `ovr_clr`  in  1  clears the sticky `ovr` flag.
- `m_valid`  out  1  result available.
- `m_period`  out  CNT_W  cycles from one rising edge to the next.
- `m_high`  out  CNT_W  cycles `pwm_in` was high within that period.
- `m_sat`  out  1  a counter saturated during this measurement.
- `m_stuck`  out  1  result is a timeout record, not a measurement.
- `m_level`  out  1  synced level at timeout; 0 when `m_stuck` = 0.
- `ovr`  out  1  sticky: a result was dropped.

## Operation
- `pwm_in` passes through `SYNC_STAGES` flops, then a delay flop. `rise` = synced & ~delayed. `s` = synced level.
- FSM states:
  - IDLE: wait for the first `rise`.
  - MEAS: counting.
- IDLE → MEAS on `rise`. Load `per_ctr` = 1 and `high_ctr` = 1.
- In MEAS on a non-rise cycle:
  - `per_ctr` += 1.
  - `high_ctr` += 1 if `s` = 1.
  - Both counters saturate at 2^CNT_W − 1 and set internal `sat`.
- In MEAS on `rise`:
  - Publish `per_ctr`, `high_ctr` and `sat`.
  - Reload the counters to 1 and clear `sat`. Stay in MEAS, so back-to-back periods are measured with no gap.
- Timeout: `idle_ctr` counts cycles since the last `rise` (or since reset in IDLE). When `idle_ctr` = TIMEOUT − 1 without a `rise`:
  - Publish period = 0, high = 0, `m_stuck` = 1, `m_level` = `s`.
  - Go to IDLE and restart `idle_ctr`. A stuck line repeats the record every TIMEOUT cycles.
- Publish rules:
  - If the output slot is empty, or `m_valid` & `m_ready` this cycle, load the result into the output registers and set `m_valid` = 1.
  - Otherwise discard the new result. The held result is unchanged. Set `ovr` = 1.
- `m_valid` falls on an accept only when no publish occurs in the same cycle.
- `ovr_clr` clears `ovr`. If a drop occurs in the same cycle, the set wins.
- Width rule: `m_high` ≤ `m_period` always. A 100 % duty line never produces `rise`, so it reports as stuck with level 1.

## Timing
- Reset values:
  - `m_valid` = 0, all payload = 0, `ovr` = 0.
  - FSM = IDLE, counters = 0, synchronizer and delay flops = 0.
- Edge latency: a `pwm_in` change registered at edge N produces `rise` during cycle N + SYNC_STAGES. `m_valid` rises one cycle later.
- Period and high counts are exact in `clk` cycles. Synchronizer latency cancels because both edges see the same delay.
- `m_valid` is held, with payload stable, until `m_valid` & `m_ready`. It never drops without an accept.
- Reset mid-measurement discards the partial counts and any held result. The first result after reset needs two rising edges.
- `rise` coinciding with timeout: the rise wins and a normal result is published.

## Structure
- Shared package `pwm_cap_pkg`: FSM state encodings (IDLE, MEAS), default `CNT_W` and `TIMEOUT` constants, and a result record typedef {period, high, sat, stuck, level}.
- Sub-module `pwm_sync_edge`: `SYNC_STAGES` synchronizer plus delay flop. Outputs `s` and `rise`, and is reused by other capture inputs.
- Top level holds the FSM, the counters, `idle_ctr` and the output slot.

## Test plan
- Periodic 3 high / 5 low with `m_ready` = 1 → after the second rise, every result is `m_period` = 8, `m_high` = 3, `m_sat` = 0, with no gaps between results.
- Duty steps 30, 13, 5 (period 100) with `m_ready` = 1 → results are high = 30, 13, 5 and period = 100 each, in order with no loss.
- `m_ready` = 0 for 3 periods of 10 → the first result is held stable and `ovr` = 1. `ovr_clr` pulse → `ovr` = 0. Accept → the held (first) value is delivered.
- `pwm_in` stuck at 1 with TIMEOUT = 20 → a record with `m_stuck` = 1, `m_level` = 1, period = 0, high = 0 every 20 cycles. Stuck at 0 → same with `m_level` = 0.
- CNT_W = 4, period 20 → `m_period` = 15 with `m_sat` = 1.
- Assert `rst` mid-period, release, then apply a 6/10 waveform → no stale result appears, and the first result after two rises is period = 10, high = 6.
